spi_slave_pwm_multi: RTL

SPI_SLAVE_PWM_MULTI -- requirements
Module: spi_slave_pwm_multi

---
 rtl/spi_slave_pwm_multi.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_pwm_multi.sv
// ---------------------------------------------------------------------------
// spi_slave_pwm_multi
//   SPI slave that receives {ADDR[7:0], DUTY[PWM_WIDTH-1:0]} frames and writes
//   DUTY into the shadow register of channel ADDR. All channels share one
//   period counter; each channel's active duty is reloaded from its shadow
//   register when the period wraps, so duty changes never produce runt pulses.
//
// Ports
//   IN_CLOCK        : sole clock, rising edge
//   IN_RESET        : synchronous active-high reset
//   IN_MOSI         : SPI data from master (asynchronous)
//   IN_CS           : SPI chip select, active low (asynchronous)
//   IN_SCLK         : SPI clock (asynchronous, <= IN_CLOCK/8)
//   OUT_PWM_SIGNAL  : registered PWM outputs, bit n = channel n
//   OUT_FRAME_DONE  : one-cycle pulse, valid frame accepted
//   OUT_FRAME_ERROR : one-cycle pulse, frame rejected
// ---------------------------------------------------------------------------
module spi_slave_pwm_multi #(
  parameter int unsigned CHANNELS                  = 4,
  parameter int unsigned PWM_WIDTH                 = 8,
  parameter logic        CPOL                      = 1'b0,
  parameter logic        CPHA                      = 1'b0,
  parameter int unsigned PACK_BIT_SEQUENCE_RECEIVE = 1,
  parameter int unsigned PRESCALE                  = 1
) (
  input  logic                IN_CLOCK,
  input  logic                IN_RESET,
  input  logic                IN_MOSI,
  input  logic                IN_CS,
  input  logic                IN_SCLK,
  output logic [CHANNELS-1:0] OUT_PWM_SIGNAL,
  output logic                OUT_FRAME_DONE,
  output logic                OUT_FRAME_ERROR
);

  localparam int unsigned          FRAME_L     = 8 + PWM_WIDTH;
  localparam int unsigned          CNT_W       = $clog2(FRAME_L + 2);
  localparam int unsigned          TICK_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0]     CNT_FULL    = CNT_W'(FRAME_L);
  localparam logic [CNT_W-1:0]     CNT_SAT     = CNT_W'(FRAME_L + 1);
  localparam logic [TICK_W-1:0]    TICK_LAST   = TICK_W'(PRESCALE - 1);
  localparam logic [PWM_WIDTH-1:0] PER_LAST    = PWM_WIDTH'((32'd1 << PWM_WIDTH) - 32'd2);
  localparam logic [7:0]           ADDR_LIM    = 8'(CHANNELS);
  localparam logic                 SAMPLE_FALL = CPOL ^ CPHA;
  localparam logic                 MSB_FIRST   = (PACK_BIT_SEQUENCE_RECEIVE != 0);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_CHECK} state_t;

  state_t               state_q, state_d;
  // Synchroniser chains: [0] first flop, [1] synchronised copy, [2] previous
  // synchronised value used for edge detection.
  logic [2:0]           cs_sync_q, cs_sync_d;
  logic [2:0]           sclk_sync_q, sclk_sync_d;
  logic [1:0]           mosi_sync_q, mosi_sync_d;
  logic [1:0]           warm_q, warm_d;
  logic                 armed_q, armed_d;
  logic [FRAME_L-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [PWM_WIDTH-1:0] period_q, period_d;
  logic [PWM_WIDTH-1:0] shadow_q [CHANNELS];
  logic [PWM_WIDTH-1:0] shadow_d [CHANNELS];
  logic [PWM_WIDTH-1:0] active_q [CHANNELS];
  logic [PWM_WIDTH-1:0] active_d [CHANNELS];
  logic [CHANNELS-1:0]  pwm_q, pwm_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 cs_fall, cs_rise, sclk_rise, sclk_fall, sample;
  logic                 tick, wrap, frame_ok;
  logic [7:0]           frame_addr;
  logic [PWM_WIDTH-1:0] frame_duty;

  // The synchronisers reset to CS high, so a CS pin held low across reset
  // would look like a fresh falling edge. armed_q only rises once the
  // synchronised CS has been seen high after the chain has refilled,
  // which keeps a frame interrupted by reset from being resumed.
  assign cs_fall   = armed_q & cs_sync_q[2] & ~cs_sync_q[1];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign sample    = SAMPLE_FALL ? sclk_fall : sclk_rise;

  assign frame_addr = shift_q[FRAME_L-1 -: 8];
  assign frame_duty = shift_q[PWM_WIDTH-1:0];
  assign frame_ok   = (cnt_q == CNT_FULL) && (frame_addr < ADDR_LIM);

  always_comb begin
    cs_sync_d   = {cs_sync_q[1:0], IN_CS};
    sclk_sync_d = {sclk_sync_q[1:0], IN_SCLK};
    mosi_sync_d = {mosi_sync_q[0], IN_MOSI};
    warm_d      = {warm_q[0], 1'b1};
    armed_d     = armed_q | (warm_q[1] & cs_sync_q[1]);
  end

  // Receiver FSM: state register
  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Receiver FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cs_fall) state_d = ST_SHIFT;
      ST_SHIFT: if (cs_rise) state_d = ST_CHECK;
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Receiver FSM: outputs (registered one cycle later as the pulses)
  always_comb begin
    done_d = 1'b0;
    err_d  = 1'b0;
    if (state_q == ST_CHECK) begin
      done_d = frame_ok;
      err_d  = ~frame_ok;
    end
  end

  // Shift register and bit counter; the counter saturates one past a full
  // frame so over-long frames are still rejected.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE && cs_fall) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (state_q == ST_SHIFT && sample) begin
      shift_d = MSB_FIRST ? {shift_q[FRAME_L-2:0], mosi_sync_q[1]}
                          : {mosi_sync_q[1], shift_q[FRAME_L-1:1]};
      if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // PWM timebase, shadow/active registers and output compare
  always_comb begin
    tick     = (tick_q == TICK_LAST);
    wrap     = tick && (period_q == PER_LAST);
    tick_d   = tick ? '0 : tick_q + TICK_W'(1);
    period_d = period_q;
    if (tick) period_d = (period_q == PER_LAST) ? '0 : period_q + PWM_WIDTH'(1);
    for (int unsigned n = 0; n < CHANNELS; n++) begin
      shadow_d[n] = shadow_q[n];
      if (done_d && frame_addr == 8'(n)) shadow_d[n] = frame_duty;
      // active loads the pre-write shadow value, so a write landing on the
      // wrap cycle waits for the following wrap.
      active_d[n] = wrap ? shadow_q[n] : active_q[n];
      pwm_d[n]    = (period_q < active_q[n]);
    end
  end

  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= {3{CPOL}};
      mosi_sync_q <= '0;
      warm_q      <= '0;
      armed_q     <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      tick_q      <= '0;
      period_q    <= '0;
      pwm_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int unsigned n = 0; n < CHANNELS; n++) begin
        shadow_q[n] <= '0;
        active_q[n] <= '0;
      end
    end else begin
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      warm_q      <= warm_d;
      armed_q     <= armed_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      period_q    <= period_d;
      pwm_q       <= pwm_d;
      done_q      <= done_d;
      err_q       <= err_d;
      for (int unsigned n = 0; n < CHANNELS; n++) begin
        shadow_q[n] <= shadow_d[n];
        active_q[n] <= active_d[n];
      end
    end
  end

  assign OUT_PWM_SIGNAL  = pwm_q;
  assign OUT_FRAME_DONE  = done_q;
  assign OUT_FRAME_ERROR = err_q;

endmodule
